// File: rtl/mux_1bit_core.sv
// Pure combinational 2:1 single-bit select. Standard ?: semantics, so an unknown
// select resolves to a only when both data inputs agree.
module mux_1bit_core (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_1bit.sv
// 2:1 single-bit mux with a clocked shadow stage: registered copy of the output
// and a saturating count of select transitions for debug visibility.
module mux_1bit #(
  parameter int   CNT_W   = 8,
  parameter logic RESET_Y = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             sel,
  output logic             y,
  output logic             y_q,
  output logic             y_q_valid,
  output logic [CNT_W-1:0] sel_chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic             y_s;
  logic             y_q_r;
  logic             valid_r;
  logic             sel_d_r;
  logic [CNT_W-1:0] cnt_r;

  mux_1bit_core u_core (
    .a   (a),
    .b   (b),
    .sel (sel),
    .y   (y_s)
  );

  // Shadow registers; the first post-reset sample is never counted because sel_d_r
  // has not yet seen a real select value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q_r   <= RESET_Y;
      valid_r <= 1'b0;
      sel_d_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
    end else begin
      y_q_r   <= y_s;
      valid_r <= 1'b1;
      sel_d_r <= sel;
      if (valid_r && (sel != sel_d_r) && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign y           = y_s;
  assign y_q         = y_q_r;
  assign y_q_valid   = valid_r;
  assign sel_chg_cnt = cnt_r;

endmodule

// File: tb/tb_mux_1bit.sv
// Self-checking bench for mux_1bit: exhaustive combinational table, directed
// latency/counter/reset sequences, and randomized traffic against a reference model.
module tb_mux_1bit;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic       b;
  logic       sel;
  logic       y;
  logic       y_q;
  logic       y_q_valid;
  logic [7:0] cnt8;
  logic       y2;
  logic       y_q2;
  logic       y_q_valid2;
  logic [1:0] cnt2;

  int checks;
  int failures;

  // reference model state: what the spec says the registered outputs should hold
  int   m_yq;
  int   m_valid;
  int   m_prev;
  int   m_cnt8;
  int   m_cnt2;

  typedef struct {
    logic a;
    logic b;
    logic sel;
    logic y;
  } vec_t;

  vec_t tbl[8];

  mux_1bit #(.CNT_W(8), .RESET_Y(1'b0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .sel         (sel),
    .y           (y),
    .y_q         (y_q),
    .y_q_valid   (y_q_valid),
    .sel_chg_cnt (cnt8)
  );

  mux_1bit #(.CNT_W(2), .RESET_Y(1'b0)) dut_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .sel         (sel),
    .y           (y2),
    .y_q         (y_q2),
    .y_q_valid   (y_q_valid2),
    .sel_chg_cnt (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, evaluated from the spec's rules with integer arithmetic.
  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      m_yq    <= 0;
      m_valid <= 0;
      m_prev  <= 0;
      m_cnt8  <= 0;
      m_cnt2  <= 0;
    end else begin
      m_yq    <= (sel == 1'b1) ? int'(b) : int'(a);
      m_valid <= 1;
      m_prev  <= int'(sel);
      if (m_valid == 1 && int'(sel) != m_prev) begin
        m_cnt8 <= (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
        m_cnt2 <= (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".y_q"},        int'(y_q),        m_yq);
    check({tag, ".y_q_valid"},  int'(y_q_valid),  m_valid);
    check({tag, ".cnt8"},       int'(cnt8),       m_cnt8);
    check({tag, ".cnt2"},       int'(cnt2),       m_cnt2);
    check({tag, ".y_q2"},       int'(y_q2),       m_yq);
  endtask

  // advance one rising edge and sample just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic na, input logic nb, input logic ns);
    a   = na;
    b   = nb;
    sel = ns;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

    // reset held: y is combinational and live, registers stay cleared
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    #1;
    check("rst_comb_y", int'(y), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_y", int'(y), 1);
      check("rst_y_q", int'(y_q), 0);
      check("rst_valid", int'(y_q_valid), 0);
      check("rst_cnt", int'(cnt8), 0);
    end

    // exhaustive combinational sweep, 1 time unit per vector, still in reset
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].sel);
      #1;
      check($sformatf("sweep_y_%0d", i), int'(y), int'(tbl[i].y));
      check($sformatf("sweep_y2_%0d", i), int'(y2), int'(tbl[i].y));
    end

    // registered latency after reset release
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1);
    step();
    check("lat_y_q", int'(y_q), 1);
    check("lat_valid", int'(y_q_valid), 1);
    check("lat_first_not_counted", int'(cnt8), 0);
    check_regs("lat");
    sel = 1'b0;
    #1;
    check("lat_y_now", int'(y), 0);
    check("lat_y_q_hold", int'(y_q), 1);
    step();
    check("lat_y_q_next", int'(y_q), 0);
    check_regs("lat2");

    // counter: fresh reset, settle, 5 toggles, then hold
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      sel = ~sel;
      step();
    end
    check("cnt_after5", int'(cnt8), 5);
    check("cnt2_sat", int'(cnt2), 3);
    check_regs("cnt5");
    for (int i = 0; i < 3; i++) begin
      step();
    end
    check("cnt_hold", int'(cnt8), 5);
    sel = ~sel;
    step();
    check("cnt2_sat_6", int'(cnt2), 3);
    check("cnt_after6", int'(cnt8), 6);

    // mid-operation reset with cnt=4 and y_q=1
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      sel = ~sel;
      step();
    end
    check("mid_pre_cnt", int'(cnt8), 4);
    check("mid_pre_y_q", int'(y_q), 1);
    rst_n = 1'b0;
    #1;
    check("mid_no_async", int'(y_q_valid), 1);
    step();
    check("mid_y_q", int'(y_q), 0);
    check("mid_valid", int'(y_q_valid), 0);
    check("mid_cnt", int'(cnt8), 0);
    drive(1'b0, 1'b1, 1'b1);
    #1;
    check("mid_y_tracks", int'(y), 1);
    rst_n = 1'b1;

    // randomized traffic, including glitchy sel between edges and sporadic resets
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1;
      drive(1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      check("rnd_y", int'(y), (sel == 1'b1) ? int'(b) : int'(a));
      if ($urandom_range(0, 3) == 0) begin
        sel = ~sel;
        #2;
        sel = 1'($urandom);
      end
      step();
      check_regs("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
